// File: rtl/level_object_reader_pkg.sv
// Shared level-generation types plus reader-side constants and helpers.
// Used by level_object_reader and its testbench.
package GlobalsPKG;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        ROCK_1     = 3'd1,
        VALUABLE_1 = 3'd2,
        VALUABLE_2 = 3'd3,
        VALUABLE_3 = 3'd4
    } LEVEL_ELEMENTS;

    localparam int MAX_OBJECTS = 32;

    typedef struct packed {
        LEVEL_ELEMENTS elementType;
        logic [10:0]   index;
    } GRABBABLE_OBJECT_METADATA;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        READY = 2'd3
    } reader_state_e;

    function automatic logic [19:0] VALUE_OF(input LEVEL_ELEMENTS t);
        case (t)
            ROCK_1:     VALUE_OF = 20'd10;
            VALUABLE_1: VALUE_OF = 20'd50;
            VALUABLE_2: VALUE_OF = 20'd150;
            VALUABLE_3: VALUE_OF = 20'd500;
            default:    VALUE_OF = 20'd0;
        endcase
    endfunction

endpackage

// File: rtl/level_grid_ram.sv
// Single-port playfield type store, synchronous read, write-first.
module level_grid_ram #(
    parameter int DEPTH = 300,
    parameter int AW    = 9,
    parameter int DW    = 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_o       <= wdata_i;
        end else begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/level_object_reader.sv
// Loads generated objects into the playfield grid and serves hook queries.
// Optional LEVEL_READER_DROP_STATS_EN adds the droppedCount output.
module level_object_reader
    import GlobalsPKG::*;
#(
    parameter int GRID_CELLS = 300,
    parameter int COUNT_W    = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     levelReady,
    input  GRABBABLE_OBJECT_METADATA elementsData [MAX_OBJECTS],
    input  logic [COUNT_W-1:0]       elementCount,
    input  logic                     queryValid,
    input  logic [10:0]              queryIndex,
    input  logic                     queryRemove,
    output logic                     busy,
    output logic                     respValid,
    output logic                     respHit,
    output LEVEL_ELEMENTS            respType,
    output logic [COUNT_W-1:0]       objectsRemaining,
    output logic [19:0]              remainingValue,
`ifdef LEVEL_READER_DROP_STATS_EN
    output logic [COUNT_W-1:0]       droppedCount,
`endif
    output logic                     levelCleared
);

    localparam int EW = $clog2(MAX_OBJECTS);

    reader_state_e state_q, state_d;
    logic          prev_q;
    logic [8:0]    ptr_q, ptr_d;
    logic [COUNT_W-1:0] num_q, num_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [19:0]   val_q, val_d;
    logic          resp_q, hit_q, rm_q;
    logic [GRID_CELLS-1:0] occ_q;

    logic          start;
    GRABBABLE_OBJECT_METADATA elem;
    logic          elem_in, elem_occ, load_wr;
    logic          q_in, q_hit, q_acc, q_rm;
    logic          ram_we;
    logic [8:0]    ram_addr;
    logic [2:0]    ram_wd, ram_rd;
    logic [19:0]   rm_val, cur_val;
    logic [20:0]   sum;

    assign start    = levelReady & ~prev_q;
    assign elem     = elementsData[ptr_q[EW-1:0]];
    assign elem_in  = elem.index < 11'(GRID_CELLS);
    assign elem_occ = elem_in && occ_q[elem.index[8:0]];
    assign load_wr  = (state_q == LOAD) && elem_in && !elem_occ && !start;
    assign q_in     = queryIndex < 11'(GRID_CELLS);
    assign q_hit    = q_in && occ_q[queryIndex[8:0]];
    assign q_acc    = queryValid && (state_q == READY) && !start;
    assign q_rm     = q_acc && queryRemove && q_hit;

    // Value of a grabbed object is known one cycle after accept (RAM read).
    assign rm_val  = rm_q ? VALUE_OF(LEVEL_ELEMENTS'(ram_rd)) : 20'd0;
    assign cur_val = (rm_val > val_q) ? 20'd0 : val_q - rm_val;
    assign sum     = {1'b0, cur_val} + {1'b0, VALUE_OF(elem.elementType)};

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = queryIndex[8:0];
        ram_wd   = NONE;
        if (state_q == CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = ptr_q;
        end else if (state_q == LOAD) begin
            ram_we   = load_wr;
            ram_addr = elem.index[8:0];
            ram_wd   = elem.elementType;
        end
    end

    level_grid_ram #(
        .DEPTH (GRID_CELLS),
        .AW    (9),
        .DW    (3)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wd),
        .rdata_o (ram_rd)
    );

`ifdef LEVEL_READER_DROP_STATS_EN
    logic [COUNT_W-1:0] drop_q, drop_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        val_d   = cur_val;
`ifdef LEVEL_READER_DROP_STATS_EN
        drop_d  = drop_q;
`endif
        if (start) begin
            state_d = CLEAR;
            ptr_d   = '0;
            num_d   = (elementCount > COUNT_W'(MAX_OBJECTS)) ?
                      COUNT_W'(MAX_OBJECTS) : elementCount;
            cnt_d   = '0;
            val_d   = '0;
`ifdef LEVEL_READER_DROP_STATS_EN
            drop_d  = '0;
`endif
        end else begin
            case (state_q)
                CLEAR: begin
                    if (ptr_q == 9'(GRID_CELLS - 1)) begin
                        ptr_d   = '0;
                        state_d = (num_q == '0) ? READY : LOAD;
                    end else begin
                        ptr_d = ptr_q + 9'd1;
                    end
                end
                LOAD: begin
                    if (load_wr) begin
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        val_d = sum[20] ? 20'hFFFFF : sum[19:0];
                    end
`ifdef LEVEL_READER_DROP_STATS_EN
                    else if (drop_q != '1) begin
                        drop_d = drop_q + 1'b1;
                    end
`endif
                    if (ptr_q == 9'(num_q) - 9'd1) begin
                        ptr_d   = '0;
                        state_d = READY;
                    end else begin
                        ptr_d = ptr_q + 9'd1;
                    end
                end
                READY: begin
                    if (q_rm && cnt_q != '0) cnt_d = cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            ptr_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            resp_q  <= 1'b0;
            hit_q   <= 1'b0;
            rm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= levelReady;
            ptr_q   <= ptr_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            resp_q  <= q_acc;
            hit_q   <= q_acc && q_hit;
            rm_q    <= q_rm;
        end
    end

`ifdef LEVEL_READER_DROP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end
    assign droppedCount = drop_q;
`endif

    // Occupancy shadow lets LOAD detect duplicates in the same cycle.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) occ_q[ptr_q] <= 1'b0;
        if (load_wr)          occ_q[elem.index[8:0]] <= 1'b1;
        if (q_rm)             occ_q[queryIndex[8:0]] <= 1'b0;
    end

    assign busy             = (state_q == CLEAR) || (state_q == LOAD);
    assign respValid        = resp_q;
    assign respHit          = hit_q;
    assign respType         = hit_q ? LEVEL_ELEMENTS'(ram_rd) : NONE;
    assign objectsRemaining = cnt_q;
    assign remainingValue   = cur_val;
    assign levelCleared     = (state_q == READY) && (cnt_q == '0);

endmodule

// File: tb/tb_level_object_reader.sv
// Directed bench with a response scoreboard and a small occupancy model.
module tb_level_object_reader;
    import GlobalsPKG::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, levelReady, queryValid, queryRemove;
    GRABBABLE_OBJECT_METADATA elems [MAX_OBJECTS];
    logic [5:0]  elementCount;
    logic [10:0] queryIndex;
    logic busy, respValid, respHit, levelCleared;
    LEVEL_ELEMENTS respType;
    logic [5:0]  objectsRemaining;
    logic [19:0] remainingValue;
`ifdef LEVEL_READER_DROP_STATS_EN
    logic [5:0]  droppedCount;
`endif

    level_object_reader dut (
        .clk              (clk),
        .reset            (reset),
        .levelReady       (levelReady),
        .elementsData     (elems),
        .elementCount     (elementCount),
        .queryValid       (queryValid),
        .queryIndex       (queryIndex),
        .queryRemove      (queryRemove),
        .busy             (busy),
        .respValid        (respValid),
        .respHit          (respHit),
        .respType         (respType),
        .objectsRemaining (objectsRemaining),
        .remainingValue   (remainingValue),
`ifdef LEVEL_READER_DROP_STATS_EN
        .droppedCount     (droppedCount),
`endif
        .levelCleared     (levelCleared)
    );

    typedef struct {
        logic          hit;
        LEVEL_ELEMENTS t;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int passed = 0;

    bit            mocc [300];
    LEVEL_ELEMENTS mgrid [300];
    int mcnt, mval, mdrop;

    function automatic int tb_val(input LEVEL_ELEMENTS t);
        if (t == ROCK_1)     return 10;
        if (t == VALUABLE_1) return 50;
        if (t == VALUABLE_2) return 150;
        if (t == VALUABLE_3) return 500;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_elem(input int i, input LEVEL_ELEMENTS t, input int idx);
        elems[i].elementType = t;
        elems[i].index       = 11'(idx);
    endtask

    task automatic model_load(input int n);
        int idx;
        mcnt = 0; mval = 0; mdrop = 0;
        for (int c = 0; c < 300; c++) mocc[c] = 1'b0;
        for (int i = 0; i < n && i < MAX_OBJECTS; i++) begin
            idx = int'(elems[i].index);
            if (idx >= 300 || mocc[idx]) mdrop++;
            else begin
                mocc[idx]  = 1'b1;
                mgrid[idx] = elems[i].elementType;
                mcnt++;
                mval += tb_val(elems[i].elementType);
            end
        end
    endtask

    task automatic raise(input int n);
        elementCount = 6'(n);
        levelReady = 1'b1;
        @(negedge clk);
        levelReady = 1'b0;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic issue(input int idx, input bit rm, input bit accept);
        exp_t e;
        queryValid  = 1'b1;
        queryIndex  = 11'(idx);
        queryRemove = rm;
        if (accept) begin
            e.hit = (idx < 300) && mocc[idx];
            e.t   = e.hit ? mgrid[idx] : NONE;
            sb.push_back(e);
            if (rm && e.hit) begin
                mocc[idx] = 1'b0;
                mcnt--;
                mval -= tb_val(e.t);
            end
        end
    endtask

    task automatic idle();
        queryValid  = 1'b0;
        queryRemove = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (respValid) begin
            if (sb.size() == 0) check("unexpected_resp", respValid, 0);
            else begin
                e = sb.pop_front();
                check("resp_hit", respHit, e.hit);
                check("resp_type", respType, e.t);
            end
        end
    end

    initial begin
        int cyc;
        reset = 1'b1; levelReady = 1'b0; elementCount = '0;
        queryValid = 1'b0; queryIndex = '0; queryRemove = 1'b0;
        for (int i = 0; i < MAX_OBJECTS; i++) set_elem(i, NONE, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_resp", respValid, 0);
        check("rst_type", respType, NONE);
        check("rst_cnt", objectsRemaining, 0);
        check("rst_val", remainingValue, 0);
        check("rst_clr", levelCleared, 0);

        // Level A
        set_elem(0, ROCK_1, 65);
        set_elem(1, VALUABLE_3, 100);
        set_elem(2, VALUABLE_1, 299);
        model_load(3);
        raise(3);
        count_busy(cyc);
        check("a_busy_cycles", cyc, 303);
        check("a_cnt", objectsRemaining, mcnt);
        check("a_val", remainingValue, mval);
        check("a_val_abs", remainingValue, 560);
        check("a_clr", levelCleared, 0);

        issue(65, 0, 1);
        @(negedge clk);
        issue(100, 1, 1);
        @(negedge clk);
        check("rm_cnt", objectsRemaining, 2);
        check("rm_val", remainingValue, 60);
        issue(100, 0, 1);
        @(negedge clk);
        issue(512, 0, 1);
        @(negedge clk);
        issue(300, 0, 1);
        @(negedge clk);
        issue(299, 0, 1);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("q_cnt", objectsRemaining, mcnt);
        check("q_val", remainingValue, mval);

        // Level B: duplicate + out of range, plus a query while busy
        for (int i = 0; i < MAX_OBJECTS; i++) set_elem(i, NONE, 0);
        set_elem(0, VALUABLE_2, 70);
        set_elem(1, ROCK_1, 70);
        set_elem(2, VALUABLE_1, 300);
        model_load(3);
        raise(3);
        repeat (10) @(negedge clk);
        issue(70, 0, 0);
        @(negedge clk);
        idle();
        count_busy(cyc);
        check("b_busy_cycles", cyc, 292);
        check("b_cnt", objectsRemaining, mcnt);
        check("b_val", remainingValue, 150);
`ifdef LEVEL_READER_DROP_STATS_EN
        check("b_drop", droppedCount, mdrop);
`endif
        issue(70, 0, 1);
        @(negedge clk);
        issue(70, 1, 1);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("b_empty_cnt", objectsRemaining, 0);
        check("b_empty_val", remainingValue, 0);
        check("b_cleared", levelCleared, 1);

        // Zero-object level
        model_load(0);
        raise(0);
        check("z_clr_busy", levelCleared, 0);
        count_busy(cyc);
        check("z_busy_cycles", cyc, 300);
        check("z_cleared", levelCleared, 1);
        check("z_cnt", objectsRemaining, 0);

        // Restart mid-LOAD
        for (int i = 0; i < MAX_OBJECTS; i++) set_elem(i, NONE, 0);
        set_elem(0, ROCK_1, 65);
        set_elem(1, VALUABLE_3, 100);
        set_elem(2, VALUABLE_1, 299);
        model_load(3);
        raise(3);
        repeat (301) @(negedge clk);
        check("mid_cnt", objectsRemaining, 1);
        levelReady = 1'b1;
        @(negedge clk);
        levelReady = 1'b0;
        check("rs_cnt", objectsRemaining, 0);
        check("rs_val", remainingValue, 0);
        check("rs_busy", busy, 1);
        count_busy(cyc);
        check("rs_busy_cycles", cyc, 303);
        check("rs_cnt_end", objectsRemaining, 3);
        check("rs_val_end", remainingValue, 560);

        // Reset mid-CLEAR
        raise(3);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mr_busy", busy, 0);
        check("mr_cnt", objectsRemaining, 0);
        check("mr_val", remainingValue, 0);
        check("mr_clr", levelCleared, 0);
        reset = 1'b0;
        @(negedge clk);
        raise(3);
        count_busy(cyc);
        check("mr_busy_cycles", cyc, 303);
        check("mr_cnt_end", objectsRemaining, 3);
        issue(100, 0, 1);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
